// File: rtl/elevator_controller.sv
// ---------------------------------------------------------------------------
// elevator_controller
//
// Six-position elevator car controller using a SCAN policy. Hall/car calls are
// latched into a pending mask; the car steps one position per TRAVEL_CYCLES
// clocks while moving and holds the doors open for DOOR_CYCLES clocks per stop.
// A call to the floor the car is standing at with open doors extends the dwell.
//
// Parameters
//   TRAVEL_CYCLES  clocks spent in MOVE per one-position step (>= 2)
//   DOOR_CYCLES    clocks the door stays open per stop (>= 1)
//
// Ports
//   clk        in   system clock, rising-edge active
//   reset      in   asynchronous active-high reset
//   call[5:0]  in   request per position (bit 0 bottom, bit 5 top), level or pulse
//   floor[5:0] out  one-hot current car position
//   direction  out  2'b10 up, 2'b01 down, 2'b00 idle (2'b11 never driven)
//   door_open  out  high while the doors are open
//   pending    out  latched outstanding requests
//
// All outputs are registered; there is no combinational path from call to
// any output.
// ---------------------------------------------------------------------------
module elevator_controller #(
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] call,
    output logic [5:0] floor,
    output logic [1:0] direction,
    output logic       door_open,
    output logic [5:0] pending
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

    // Outcome of the scheduling decision at a given position.
    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_DOOR = 2'd1,
        D_UP   = 2'd2,
        D_DOWN = 2'd3
    } dec_t;

    localparam int CNT_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last_dir;   // 1 = up

    logic [5:0] req;
    logic [5:0] step_floor;
    logic [5:0] clear;
    dec_t       dec_here;
    dec_t       dec_arrive;
    dec_t       dec_leave;
    logic       travel_done;
    logic       dwell_done;
    logic       own_call;

    // SCAN decision: serve the position itself first, otherwise keep going in
    // the preferred direction while it still has requests, otherwise turn.
    // A direction is only ever chosen when requests exist beyond the car, so
    // the one-hot position can never be shifted off either end.
    function automatic dec_t decide(input logic [5:0] pos,
                                    input logic [5:0] r,
                                    input logic       up_pref);
        logic [5:0] below_mask;
        logic [5:0] above_mask;
        logic       any_above;
        logic       any_below;
        below_mask = pos - 6'd1;               // all bits below a one-hot pos
        above_mask = ~(below_mask | pos);
        any_above  = |(r & above_mask);
        any_below  = |(r & below_mask);
        if (|(r & pos))
            return D_DOOR;
        else if (any_above && (up_pref || !any_below))
            return D_UP;
        else if (any_below)
            return D_DOWN;
        else
            return D_IDLE;
    endfunction

    // Same-cycle calls take part in every decision.
    assign req         = pending | call;
    assign step_floor  = last_dir ? {floor[4:0], 1'b0} : {1'b0, floor[5:1]};
    assign travel_done = (cnt == TRAVEL_LAST);
    assign dwell_done  = (cnt == DOOR_LAST);
    assign own_call    = |(call & floor);

    always_comb begin
        dec_here   = decide(floor, req, last_dir);
        dec_arrive = decide(step_floor, req, last_dir);
        // Leaving the door: the floor just served no longer counts.
        dec_leave  = decide(floor, req & ~floor, last_dir);
    end

    // Requests for the floor whose doors are opening, or are open, are
    // absorbed rather than latched.
    always_comb begin
        clear = 6'b000000;
        case (state)
            IDLE:    if (dec_here == D_DOOR) clear = floor;
            MOVE:    if (travel_done && dec_arrive == D_DOOR) clear = step_floor;
            DOOR:    clear = floor;
            default: clear = 6'b000000;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            floor     <= 6'b000001;
            direction <= 2'b00;
            door_open <= 1'b0;
            pending   <= 6'b000000;
            cnt       <= '0;
            last_dir  <= 1'b1;
        end else begin
            pending <= req & ~clear;

            case (state)
                IDLE: begin
                    direction <= 2'b00;
                    door_open <= 1'b0;
                    cnt       <= '0;
                    case (dec_here)
                        D_DOOR: begin
                            state     <= DOOR;
                            door_open <= 1'b1;
                        end
                        D_UP: begin
                            state     <= MOVE;
                            last_dir  <= 1'b1;
                            direction <= 2'b10;
                        end
                        D_DOWN: begin
                            state     <= MOVE;
                            last_dir  <= 1'b0;
                            direction <= 2'b01;
                        end
                        default: state <= IDLE;
                    endcase
                end

                MOVE: begin
                    if (!travel_done) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        floor <= step_floor;
                        cnt   <= '0;
                        // Decide at the arriving position. Continuing keeps
                        // MOVE; a turn-around always passes through IDLE.
                        case (dec_arrive)
                            D_DOOR: begin
                                state     <= DOOR;
                                door_open <= 1'b1;
                            end
                            D_UP: begin
                                if (!last_dir) begin
                                    state     <= IDLE;
                                    direction <= 2'b00;
                                end
                            end
                            D_DOWN: begin
                                if (last_dir) begin
                                    state     <= IDLE;
                                    direction <= 2'b00;
                                end
                            end
                            default: begin
                                state     <= IDLE;
                                direction <= 2'b00;
                            end
                        endcase
                    end
                end

                DOOR: begin
                    if (own_call) begin
                        // Dwell extension: restart the door timer.
                        cnt <= '0;
                    end else if (!dwell_done) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt       <= '0;
                        door_open <= 1'b0;
                        // Continue in the travel direction directly; a turn
                        // goes through IDLE, which then sets the new heading.
                        if (dec_leave == D_UP && last_dir) begin
                            state     <= MOVE;
                            direction <= 2'b10;
                        end else if (dec_leave == D_DOWN && !last_dir) begin
                            state     <= MOVE;
                            direction <= 2'b01;
                        end else begin
                            state     <= IDLE;
                            direction <= 2'b00;
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    direction <= 2'b00;
                    door_open <= 1'b0;
                    cnt       <= '0;
                end
            endcase
        end
    end

endmodule
